vga_data_ctrl: RTL and testbench
================================

Name: vga_data_ctrl

Overview:
Fetch engine between the VGA timing generator and the shared SRAM bus arbiter. It turns the pixel word address requested by the VGA pipeline into SRAM read requests and buffers the returned 32-bit word. It presents that word to the pixel serializer during the active video region only. One 32-bit word covers 4 consecutive pixel clocks; the VGA side advances the requested address once per 4 clocks.

Parameters:
ADDR_W, 32, width of the request and SRAM address buses
DATA_W, 32, width of the SRAM data word and the data_to_VGA bus
ST_ACTIVE, 2, VGA_state encoding for the active video region
ST_PREFETCH, 1, VGA_state encoding for back porch; fetching is allowed but output stays blanked

Ports:
clk  in  1  pixel clock, 25 MHz
nrst  in  1  reset; one clock; reset is asynchronous and active-high (nrst=1 resets)
VGA_request_address  in  ADDR_W  word address the VGA pipeline wants next
data_from_SRAM  in  DATA_W  read data returned by the SRAM/arbiter
h_count  in  10  horizontal pixel counter from the timing generator
VGA_state  in  2  horizontal region: 0 sync, 1 back porch, 2 active, 3 front porch
data_en  in  1  SRAM read-data-valid strobe
byte_select_in  in  4  byte lane enables requested by the VGA side
byte_select_out  out  4  byte lane enables driven to SRAM with the request
read  out  1  SRAM read request
data_to_VGA  out  DATA_W  buffered pixel word to the serializer
SRAM_address  out  ADDR_W  address driven to SRAM

Behaviour:
- Reset (nrst=1, async):
  - read=0, SRAM_address=0, byte_select_out=0, data_to_VGA=0.
  - Internal word buffer=0, last_addr=0, valid=0, FSM=IDLE.
- FSM states are IDLE, FETCH and HOLD. All outputs except data_to_VGA are registered.
- Fetch trigger, sampled at posedge: VGA_state is ST_PREFETCH or ST_ACTIVE, and either valid=0 or VGA_request_address != last_addr.
- On the trigger edge, from IDLE, HOLD or FETCH:
  - state<=FETCH, read<=1.
  - SRAM_address<=VGA_request_address, last_addr<=VGA_request_address.
  - byte_select_out<=byte_select_in, valid<=1.
  - read therefore rises 1 cycle after the new address is presented.
- In FETCH, read stays 1 and SRAM_address stays stable until data_en=1 is sampled. On that edge:
  - buffer<=data_from_SRAM, state<=HOLD, read<=0.
  - If a new trigger is also present on that edge, the trigger wins: buffer still captures, state stays FETCH with the new address, read stays 1.
- data_en=1 while not in FETCH is ignored; the buffer is unchanged.
- HOLD: read=0 and the buffer is held until the next trigger.
- When VGA_state is 0 or 3 on a posedge:
  - state<=IDLE, read<=0.
  - Any outstanding fetch is abandoned and valid<=0, so the first address of the next line is always refetched.
  - The buffer is retained.
- Line start: h_count==0 clears valid (same effect as a blanking state).
- data_to_VGA is combinational: buffer when VGA_state==ST_ACTIVE, else 0. Blanking forces black.
- With data_en tied high, the buffer updates 2 cycles after a new address appears: 1 cycle to assert read, then the capture edge. A word requested at pixel 4k is therefore on data_to_VGA from pixel 4k+2.
- No arithmetic on addresses; request address is passed through unmodified. Address compare is full width.
- Reset asserted mid-fetch drops read immediately (asynchronous) and returns to IDLE.

Test Plan:
- Reset: nrst=1 for 2 cycles -> read=0, SRAM_address=0, byte_select_out=0, data_to_VGA=0. Outputs stay at these values with nrst=1 regardless of other inputs.
- Sync region: VGA_state=0 for 96 cycles, address incrementing every 4 cycles, data_en=1 -> read never asserts, data_to_VGA=0 throughout.
- Back-porch prefetch:
  - Stimulus: VGA_state=1, address 0 then 1 after 4 cycles, memory[0]=0x00000000, memory[1]=0xFFFFFFFF, data_en=1, byte_select_in=4'b1111.
  - Response: read pulses once per address change, SRAM_address follows 0 then 1, byte_select_out=4'b1111, data_to_VGA stays 0.
- Active line:
  - Stimulus: VGA_state=2 for 640 cycles, address incrementing every 4 cycles, memory pattern 0x00000000, 0xFFFFFFFF, 0x6AAA5556, 0x95559AAA repeating.
  - Response: data_to_VGA shows each pattern word starting 2 cycles after its address appears; 160 read pulses in total.
- Handshake stall: data_en=0 for 5 cycles after read rises -> read and SRAM_address stay stable and the buffer is unchanged. With data_en=1, the word is captured on that edge and read drops the next cycle.
- Mid-fetch abort: with read=1, switch VGA_state 2->3 -> read=0 after 1 edge and data_to_VGA=0. On return to state 1, the same address is refetched (read asserts again).

Source files
------------

// File: rtl/vga_data_ctrl.sv
// Fetch engine between the VGA timing generator and the SRAM arbiter: turns requested
// word addresses into SRAM reads and buffers the returned word for the pixel serializer.
module vga_data_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter logic [1:0]  ST_ACTIVE   = 2'd2,
    parameter logic [1:0]  ST_PREFETCH = 2'd1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] VGA_request_address,
    input  logic [DATA_W-1:0] data_from_SRAM,
    input  logic [9:0]        h_count,
    input  logic [1:0]        VGA_state,
    input  logic              data_en,
    input  logic [3:0]        byte_select_in,
    output logic [3:0]        byte_select_out,
    output logic              read,
    output logic [DATA_W-1:0] data_to_VGA,
    output logic [ADDR_W-1:0] SRAM_address
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e              state_q, state_d;
    logic                read_q, read_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [3:0]          bsel_q, bsel_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   buf_q, buf_d;

    logic fetch_region;
    logic line_clear;
    logic trigger;
    logic capture;

    always_comb begin
        fetch_region = (VGA_state == ST_PREFETCH) || (VGA_state == ST_ACTIVE);
        // Blanking or line start forces the next line's first word to be refetched.
        line_clear   = !fetch_region || (h_count == 10'd0);
        trigger      = fetch_region && (!valid_q || (VGA_request_address != last_addr_q));
        capture      = (state_q == StFetch) && data_en;

        state_d     = state_q;
        read_d      = read_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        bsel_d      = bsel_q;
        valid_d     = valid_q;
        buf_d       = buf_q;

        if (line_clear) begin
            state_d = StIdle;
            read_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            if (capture) begin
                buf_d = data_from_SRAM;
            end
            // A new request outranks completion of the current one.
            if (trigger) begin
                state_d     = StFetch;
                read_d      = 1'b1;
                addr_d      = VGA_request_address;
                last_addr_d = VGA_request_address;
                bsel_d      = byte_select_in;
                valid_d     = 1'b1;
            end else if (capture) begin
                state_d = StHold;
                read_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q     <= StIdle;
            read_q      <= 1'b0;
            addr_q      <= '0;
            last_addr_q <= '0;
            bsel_q      <= '0;
            valid_q     <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            bsel_q      <= bsel_d;
            valid_q     <= valid_d;
            buf_q       <= buf_d;
        end
    end

    always_comb begin
        read            = read_q;
        SRAM_address    = addr_q;
        byte_select_out = bsel_q;
        data_to_VGA     = (VGA_state == ST_ACTIVE) ? buf_q : '0;
    end

endmodule

// File: tb/tb_vga_data_ctrl.sv
// Self-checking bench for vga_data_ctrl: scoreboard queues for fetched addresses and words,
// a vector table for output blanking, and hand-written stall/abort/reset sequences.
`timescale 1ns/1ps
module tb_vga_data_ctrl;

    logic        tb_clk = 1'b0;
    logic        nrst;
    logic [31:0] VGA_request_address;
    logic [31:0] data_from_SRAM;
    logic [9:0]  h_count;
    logic [1:0]  VGA_state;
    logic        data_en;
    logic [3:0]  byte_select_in;
    logic [3:0]  byte_select_out;
    logic        read;
    logic [31:0] data_to_VGA;
    logic [31:0] SRAM_address;

    int errors = 0;
    int checks = 0;

    logic [31:0] addr_sb[$];
    logic [31:0] data_sb[$];
    logic [3:0]  bsel_sb[$];

    typedef struct {
        logic [1:0]  st;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[5];

    always #5 tb_clk = ~tb_clk;

    vga_data_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .ST_ACTIVE   (2'd2),
        .ST_PREFETCH (2'd1)
    ) dut (
        .clk                 (tb_clk),
        .nrst                (nrst),
        .VGA_request_address (VGA_request_address),
        .data_from_SRAM      (data_from_SRAM),
        .h_count             (h_count),
        .VGA_state           (VGA_state),
        .data_en             (data_en),
        .byte_select_in      (byte_select_in),
        .byte_select_out     (byte_select_out),
        .read                (read),
        .data_to_VGA         (data_to_VGA),
        .SRAM_address        (SRAM_address)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        case (a[1:0])
            2'd0:    pat = 32'h0000_0000;
            2'd1:    pat = 32'hFFFF_FFFF;
            2'd2:    pat = 32'h6AAA_5556;
            default: pat = 32'h9555_9AAA;
        endcase
    endfunction

    always_comb data_from_SRAM = pat(SRAM_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Pops the expected address/byte-enables when a read pulse starts.
    task automatic check_rise(input string name, inout logic prev_rd, inout int nrise);
        if (read && !prev_rd) begin
            nrise++;
            if (addr_sb.size() == 0 || bsel_sb.size() == 0) begin
                check({name, "_unexpected_read"}, 32'(read), 32'd0);
            end else begin
                check({name, "_addr"}, SRAM_address, addr_sb.pop_front());
                check({name, "_bsel"}, 32'(byte_select_out), 32'(bsel_sb.pop_front()));
            end
        end
        prev_rd = read;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        prev_rd;
        int          nrise;
        logic [31:0] cur;

        vecs[0] = '{st: 2'd2, exp: 32'h9555_9AAA};
        vecs[1] = '{st: 2'd0, exp: 32'h0000_0000};
        vecs[2] = '{st: 2'd1, exp: 32'h0000_0000};
        vecs[3] = '{st: 2'd3, exp: 32'h0000_0000};
        vecs[4] = '{st: 2'd2, exp: 32'h9555_9AAA};

        // Reset held with live-looking inputs
        nrst                = 1'b1;
        VGA_state           = 2'd2;
        data_en             = 1'b1;
        h_count             = 10'd200;
        byte_select_in      = 4'hF;
        for (int i = 0; i < 2; i++) begin
            VGA_request_address = $urandom;
            step();
            check("rst_read", 32'(read), 32'd0);
            check("rst_addr", SRAM_address, 32'd0);
            check("rst_bsel", 32'(byte_select_out), 32'd0);
            check("rst_data", data_to_VGA, 32'd0);
        end
        nrst = 1'b0;

        // Sync region: never fetch, always black
        prev_rd = 1'b0;
        nrise   = 0;
        VGA_state = 2'd0;
        for (int i = 0; i < 96; i++) begin
            VGA_request_address = 32'(i / 4);
            step();
            if (read) nrise++;
            check("sync_data", data_to_VGA, 32'd0);
        end
        check("sync_reads", 32'(nrise), 32'd0);

        // Back porch prefetch: fetches allowed, output blanked
        nrise = 0;
        VGA_state = 2'd1;
        byte_select_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            VGA_request_address = (i < 4) ? 32'd0 : 32'd1;
            if (i % 4 == 0) begin
                addr_sb.push_back(VGA_request_address);
                bsel_sb.push_back(4'b1111);
            end
            step();
            check_rise("bp", prev_rd, nrise);
            check("bp_data", data_to_VGA, 32'd0);
        end
        check("bp_reads", 32'(nrise), 32'd2);

        // Active line: word for address at pixel 4k visible from pixel 4k+2
        nrise = 0;
        cur   = '0;
        VGA_state = 2'd2;
        for (int i = 0; i < 640; i++) begin
            VGA_request_address = 32'(i / 4);
            byte_select_in      = 4'(i / 4);
            if (i % 4 == 0) begin
                addr_sb.push_back(VGA_request_address);
                bsel_sb.push_back(byte_select_in);
                data_sb.push_back(pat(VGA_request_address));
            end
            step();
            check_rise("act", prev_rd, nrise);
            if (i % 4 == 1) begin
                if (data_sb.size() == 0) check("act_sb_empty", 32'd0, 32'd1);
                else cur = data_sb.pop_front();
            end
            if (i % 4 != 0) check("act_data", data_to_VGA, cur);
        end
        check("act_reads", 32'(nrise), 32'd160);
        check("act_addr_sb_left", 32'(addr_sb.size()), 32'd0);
        check("act_data_sb_left", 32'(data_sb.size()), 32'd0);

        // Output blanking is combinational on VGA_state; buffer is retained
        for (int i = 0; i < 5; i++) begin
            VGA_state = vecs[i].st;
            #1;
            check("blank_vec", data_to_VGA, vecs[i].exp);
        end
        VGA_state = 2'd2;

        // Handshake stall
        data_en = 1'b0;
        VGA_request_address = 32'h0000_0102;
        step();
        check("stall_read", 32'(read), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_read_hold", 32'(read), 32'd1);
            check("stall_addr_hold", SRAM_address, 32'h0000_0102);
            check("stall_buf_hold", data_to_VGA, 32'h9555_9AAA);
        end
        data_en = 1'b1;
        step();
        check("stall_capture", data_to_VGA, 32'h6AAA_5556);
        check("stall_read_drop", 32'(read), 32'd0);

        // Mid-fetch abort and refetch of the same address
        data_en = 1'b0;
        VGA_request_address = 32'h0000_0203;
        step();
        check("abort_read_up", 32'(read), 32'd1);
        VGA_state = 2'd3;
        #1;
        check("abort_black", data_to_VGA, 32'd0);
        step();
        check("abort_read_drop", 32'(read), 32'd0);
        VGA_state = 2'd1;
        step();
        check("refetch_read", 32'(read), 32'd1);
        check("refetch_addr", SRAM_address, 32'h0000_0203);
        data_en = 1'b1;
        step();
        check("refetch_done", 32'(read), 32'd0);
        VGA_state = 2'd2;
        #1;
        check("refetch_data", data_to_VGA, 32'h9555_9AAA);

        // Line start clears valid: same address gets fetched again
        nrise   = 0;
        prev_rd = read;
        h_count = 10'd0;
        step();
        if (read && !prev_rd) nrise++;
        prev_rd = read;
        h_count = 10'd200;
        step();
        if (read && !prev_rd) nrise++;
        check("hzero_refetch", 32'(nrise), 32'd1);
        step();
        check("hzero_addr", SRAM_address, 32'h0000_0203);

        // Asynchronous reset mid-fetch
        data_en = 1'b0;
        VGA_request_address = 32'h0000_0300;
        step();
        check("arst_pre_read", 32'(read), 32'd1);
        #2;
        nrst = 1'b1;
        #1;
        check("arst_read", 32'(read), 32'd0);
        check("arst_addr", SRAM_address, 32'd0);
        check("arst_data", data_to_VGA, 32'd0);
        step();
        check("arst_hold_read", 32'(read), 32'd0);
        check("arst_hold_bsel", 32'(byte_select_out), 32'd0);
        nrst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
